fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: AW, default 8, program-counter/instruction-address width.
REQ-002 Parameter: TMO, default 15, max FETCH cycles waiting for mem_ack before fault.
REQ-003 clk  in  1  single clock; all registers on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 step  in  1  raw single-step request; asynchronous to clk.
REQ-006 run  in  1  1 = free-run, 0 = one instruction per step.
REQ-007 mem_req  out  1  instruction read request, held until ack.
REQ-008 mem_addr  out  AW  fetch address; equals pc.
REQ-009 mem_ack  in  1  read complete; mem_rdata valid this cycle.
REQ-010 mem_rdata  in  16  instruction word.
REQ-011 ir  out  16  instruction register.
REQ-012 OpCode  out  5  ir[15:11], to decoder.
REQ-013 pc  out  AW  program counter.
REQ-014 exec_en  out  1  one-cycle execute strobe; gates register-file/memory writes downstream.
REQ-015 LDPC, LDIR, JZ, JC, JUMP  in  1 each  decoder controls for the current OpCode.
REQ-016 flag_we, z_in, c_in  in  1 each  ALU flag write enable and flag values.
REQ-017 fault  out  1  sticky fetch-timeout indicator.
REQ-018 halted  out  1  high in HALT state.

Function
REQ-019 States: IDLE, FETCH, EXEC, HALT; encoded state register, no other states reachable.
REQ-020 step passes a 2-FF synchronizer then rising-edge detect; held-high step yields exactly one step_pulse.
REQ-021 IDLE: go FETCH when run=1 or step_pulse=1; else stay.
REQ-022 FETCH: mem_req=1, mem_addr=pc; on mem_ack=1 load ir<=mem_rdata, go EXEC next cycle.
REQ-023 FETCH wait counter starts at 0 on entry; if TMO cycles elapse with no ack: fault<=1, mem_req drops, go IDLE, pc and ir unchanged.
REQ-024 fault cleared only by rst.
REQ-025 mem_ack outside FETCH ignored; step_pulse outside IDLE ignored (not queued).
REQ-026 EXEC lasts exactly one cycle, exec_en=1 only in EXEC.
REQ-027 taken = JUMP | (JZ & zf) | (JC & cf), using registered flags zf/cf before any EXEC-cycle update.
REQ-028 EXEC with LDPC=1: pc <= taken ? ir[AW-1:0] : pc+1, modulo 2^AW (wrap 0xFF->0x00 at AW=8).
REQ-029 EXEC with LDPC=0: pc unchanged.
REQ-030 EXEC with flag_we=1: zf<=z_in, cf<=c_in at end of EXEC; flag_we outside EXEC ignored.
REQ-031 EXEC exit: LDIR=1 -> FETCH if run=1, else IDLE; LDIR=0 -> HALT.
REQ-032 HALT: halted=1, no fetches; left only by rst.
REQ-033 Latency free-run, zero-wait memory: FETCH(1)+EXEC(1) = 2 cycles per instruction.
REQ-034 run changes are sampled only at IDLE and EXEC exit decisions.

Reset
REQ-035 rst=1 forces asynchronously: state=IDLE, pc=0, ir=0 (OpCode=NOP), mem_req=0, exec_en=0, zf=cf=0, fault=0, halted=0, synchronizer/edge regs=0, wait counter=0.
REQ-036 rst asserted mid-FETCH drops mem_req in the same cycle; a late mem_ack after release is ignored.

Verification
REQ-037 run=0, step pulse (held 10 cycles), mem acks in 1 cycle with 16'h0800 -> exactly one mem_req, ir=16'h0800, OpCode=1, one exec_en, pc 0->1, back to IDLE.
REQ-038 run=1, pc=8'hFF, LDPC=1, no jump -> pc wraps to 8'h00, next mem_addr=8'h00.
REQ-039 zf=1 from prior flag_we, ir=16'h5842, JZ=1 -> pc=8'h42; same with zf=0 -> pc=old pc+1.
REQ-040 mem_ack never asserted -> mem_req high exactly TMO=15 cycles, fault=1, state IDLE, pc unchanged.
REQ-041 EXEC with flag_we=1,z_in=1 and JZ=1, prior zf=0 -> jump not taken, zf=1 afterward.
REQ-042 LDIR=0 in EXEC -> halted=1, no further mem_req despite run=1/step; rst clears all outputs to reset values.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// The request is held until the memory returns an acknowledge.
interface fetch_unit_if #(
    parameter int AW = 8
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [15:0]   mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch/execute sequencer: IDLE -> FETCH -> EXEC, with free-run or
// single-step operation, conditional PC load, fetch timeout fault and HALT.
module fetch_unit #(
    parameter int AW  = 8,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          run,
    fetch_unit_if.master  mem,
    output logic [15:0]   ir,
    output logic [4:0]    OpCode,
    output logic [AW-1:0] pc,
    output logic          exec_en,
    input  logic          LDPC,
    input  logic          LDIR,
    input  logic          JZ,
    input  logic          JC,
    input  logic          JUMP,
    input  logic          flag_we,
    input  logic          z_in,
    input  logic          c_in,
    output logic          fault,
    output logic          halted
);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          step_meta;
    logic          step_sync;
    logic          step_prev;
    logic          step_pulse;
    logic          zf;
    logic          cf;
    logic          taken;

    assign step_pulse    = step_sync & ~step_prev;
    assign taken         = JUMP | (JZ & zf) | (JC & cf);
    assign mem.mem_addr  = pc;
    assign OpCode        = ir[15:11];

    // step is asynchronous: two flops before the edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
            step_prev <= step_sync;
        end
    end

    // NOTE: every register here uses <= so all branches see the pre-edge values
    // (EXEC reads zf/cf before they are rewritten in the same cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            mem.mem_req <= 1'b0;
            exec_en     <= 1'b0;
            zf          <= 1'b0;
            cf          <= 1'b0;
            fault       <= 1'b0;
            halted      <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            exec_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (run || step_pulse) begin
                        state       <= FETCH;
                        mem.mem_req <= 1'b1;
                        wait_cnt    <= '0;
                    end
                end
                FETCH: begin
                    if (mem.mem_ack) begin
                        ir          <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        exec_en     <= 1'b1;
                        state       <= EXEC;
                    end else if (wait_cnt == CW'(TMO - 1)) begin
                        // Timeout abandons the fetch; pc and ir keep their values.
                        fault       <= 1'b1;
                        mem.mem_req <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (LDPC) pc <= taken ? ir[AW-1:0] : pc + 1'b1;
                    if (flag_we) begin
                        zf <= z_in;
                        cf <= c_in;
                    end
                    if (!LDIR) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (run) begin
                        state       <= FETCH;
                        mem.mem_req <= 1'b1;
                        wait_cnt    <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// free-run program checked against an instruction-level model of pc and flags.
module tb_fetch_unit;
    localparam int AW  = 8;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          step = 1'b0;
    logic          run = 1'b0;
    logic [15:0]   ir;
    logic [4:0]    OpCode;
    logic [AW-1:0] pc;
    logic          exec_en;
    logic          LDPC = 1'b0, LDIR = 1'b0, JZ = 1'b0, JC = 1'b0, JUMP = 1'b0;
    logic          flag_we = 1'b0, z_in = 1'b0, c_in = 1'b0;
    logic          fault;
    logic          halted;

    fetch_unit_if #(.AW(AW)) mem_bus ();

    fetch_unit #(.AW(AW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .step(step), .run(run), .mem(mem_bus),
        .ir(ir), .OpCode(OpCode), .pc(pc), .exec_en(exec_en),
        .LDPC(LDPC), .LDIR(LDIR), .JZ(JZ), .JC(JC), .JUMP(JUMP),
        .flag_we(flag_we), .z_in(z_in), .c_in(c_in),
        .fault(fault), .halted(halted)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] mem_array [256];
    bit          ack_en = 1'b1;
    int          ack_lat = 0;
    int          ack_wait = 0;
    bit          stray_ack = 1'b0;

    // Memory model: acknowledges a held request after ack_lat wait cycles.
    always @(negedge clk) begin
        if (mem_bus.mem_req && ack_en && ack_wait >= ack_lat) begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = mem_array[mem_bus.mem_addr];
        end else if (mem_bus.mem_req) begin
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = 16'($urandom);
            ack_wait++;
        end else begin
            mem_bus.mem_ack   = stray_ack;
            mem_bus.mem_rdata = 16'hFFFF;
            ack_wait = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] ctl(input bit ldpc, ldir, jz, jc, jump, fwe, z, c);
        return {ldpc, ldir, jz, jc, jump, fwe, z, c};
    endfunction

    // NOTE: bench inputs are driven with blocking assignments at the falling edge,
    // half a cycle away from the edge where the DUT samples them.
    task automatic drive(input logic [7:0] c);
        {LDPC, LDIR, JZ, JC, JUMP, flag_we, z_in, c_in} = c;
    endtask

    task automatic drive_junk();
        drive(8'($urandom));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_junk();
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; stray_ack = 1'b0;
        ack_en = 1'b1; ack_lat = 0; drive('0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the EXEC strobe and applies the decoder controls for that cycle.
    task automatic exec_step(input logic [7:0] c, output bit ok, output logic [15:0] ir_o,
                             output logic [4:0] op_o, output logic [AW-1:0] pc_o, output int waited);
        ok = 1'b0; waited = -1; ir_o = 'x; op_o = 'x; pc_o = 'x;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (exec_en) begin
                drive(c);
                ir_o = ir; op_o = OpCode; pc_o = pc; ok = 1'b1; waited = i;
            end else begin
                drive_junk();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; step = 1'b1; drive(8'hFF);
        repeat (2) @(negedge clk);
        checks++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b expected 0", mem_bus.mem_req); end
        checks++; if (exec_en !== 1'b0) begin failures++; $display("FAIL reset_exec_en: got %b expected 0", exec_en); end
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc: got %h expected 00", pc); end
        checks++; if (mem_bus.mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr: got %h expected 00", mem_bus.mem_addr); end
        checks++; if (ir !== 16'h0000) begin failures++; $display("FAIL reset_ir: got %h expected 0000", ir); end
        checks++; if (OpCode !== 5'd0) begin failures++; $display("FAIL reset_opcode: got %0d expected 0", OpCode); end
        checks++; if ({fault, halted} !== 2'b00) begin failures++; $display("FAIL reset_fault_halted: got %b expected 00", {fault, halted}); end
    endtask

    task automatic test_single_step();
        int req_cnt = 0, exec_cnt = 0;
        bit ok; logic [15:0] ir_o; logic [4:0] op_o; logic [AW-1:0] pc_o, addr_seen; int w;
        do_reset();
        mem_array[0] = 16'h0800;
        mem_array[1] = 16'h1234;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_bus.mem_req) req_cnt++;
            if (exec_en) begin exec_cnt++; drive(ctl(1, 1, 0, 0, 0, 0, 0, 0)); end
            else drive_junk();
            if (i == 2) begin #3 step = 1'b1; end
            if (i == 12) step = 1'b0;
        end
        checks++; if (req_cnt !== 1) begin failures++; $display("FAIL step_req_cycles: got %0d expected 1", req_cnt); end
        checks++; if (exec_cnt !== 1) begin failures++; $display("FAIL step_exec_cycles: got %0d expected 1", exec_cnt); end
        checks++; if (ir !== 16'h0800) begin failures++; $display("FAIL step_ir: got %h expected 0800", ir); end
        checks++; if (OpCode !== 5'd1) begin failures++; $display("FAIL step_opcode: got %0d expected 1", OpCode); end
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL step_pc: got %h expected 01", pc); end
        // A second step must start a new fetch, proving the unit went back to IDLE.
        step = 1'b1;
        ok = 1'b0; addr_seen = 'x;
        for (int i = 0; i < 10 && !ok; i++) begin
            idle_cycle();
            if (mem_bus.mem_req) begin ok = 1'b1; addr_seen = mem_bus.mem_addr; end
        end
        checks++; if (addr_seen !== 8'h01) begin failures++; $display("FAIL step_second_fetch_addr: got %h expected 01", addr_seen); end
        exec_step(ctl(1, 1, 0, 0, 0, 0, 0, 0), ok, ir_o, op_o, pc_o, w);
        step = 1'b0;
        checks++; if (ir_o !== 16'h1234) begin failures++; $display("FAIL step_second_ir: got %h expected 1234", ir_o); end
    endtask

    task automatic test_wrap();
        bit ok; logic [15:0] ir_o; logic [4:0] op_o; logic [AW-1:0] pc_o; int w;
        do_reset();
        mem_array[8'h00] = 16'h00FF;
        mem_array[8'hFF] = 16'h0000;
        run = 1'b1;
        exec_step(ctl(1, 1, 0, 0, 1, 0, 0, 0), ok, ir_o, op_o, pc_o, w);
        exec_step(ctl(1, 1, 0, 0, 0, 0, 0, 0), ok, ir_o, op_o, pc_o, w);
        checks++; if (pc_o !== 8'hFF) begin failures++; $display("FAIL wrap_jump_pc: got %h expected ff", pc_o); end
        checks++; if (w !== 1) begin failures++; $display("FAIL freerun_latency: got %0d idle edges expected 1", w); end
        idle_cycle();
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL wrap_pc: got %h expected 00", pc); end
        checks++; if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 8'h00}) begin
            failures++; $display("FAIL wrap_fetch: got req=%b addr=%h expected req=1 addr=00", mem_bus.mem_req, mem_bus.mem_addr); end
    endtask

    task automatic test_jz();
        bit ok; logic [15:0] ir_o; logic [4:0] op_o; logic [AW-1:0] pc_o; int w;
        do_reset();
        mem_array[8'h00] = 16'h0000; mem_array[8'h01] = 16'h5842;
        mem_array[8'h42] = 16'h0000; mem_array[8'h43] = 16'h5842;
        run = 1'b1;
        exec_step(ctl(1, 1, 0, 0, 0, 1, 1, 0), ok, ir_o, op_o, pc_o, w);
        exec_step(ctl(1, 1, 1, 0, 0, 0, 0, 0), ok, ir_o, op_o, pc_o, w);
        checks++; if (op_o !== 5'd11) begin failures++; $display("FAIL jz_opcode: got %0d expected 11", op_o); end
        idle_cycle();
        checks++; if (pc !== 8'h42) begin failures++; $display("FAIL jz_taken_pc: got %h expected 42", pc); end
        exec_step(ctl(1, 1, 0, 0, 0, 1, 0, 0), ok, ir_o, op_o, pc_o, w);
        exec_step(ctl(1, 1, 1, 0, 0, 0, 0, 0), ok, ir_o, op_o, pc_o, w);
        idle_cycle();
        checks++; if (pc !== 8'h44) begin failures++; $display("FAIL jz_not_taken_pc: got %h expected 44", pc); end
    endtask

    task automatic test_flag_same_cycle();
        bit ok; logic [15:0] ir_o; logic [4:0] op_o; logic [AW-1:0] pc_o; int w;
        do_reset();
        mem_array[0] = 16'h5842; mem_array[1] = 16'h5842;
        run = 1'b1;
        exec_step(ctl(1, 1, 1, 0, 0, 1, 1, 0), ok, ir_o, op_o, pc_o, w);
        idle_cycle();
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL flag_old_zf_pc: got %h expected 01", pc); end
        exec_step(ctl(1, 1, 1, 0, 0, 0, 0, 0), ok, ir_o, op_o, pc_o, w);
        idle_cycle();
        checks++; if (pc !== 8'h42) begin failures++; $display("FAIL flag_new_zf_pc: got %h expected 42", pc); end
    endtask

    task automatic test_timeout();
        int req_cnt = 0, exec_cnt = 0; bit fault_early = 1'b0;
        bit ok; logic [15:0] ir_o; logic [4:0] op_o; logic [AW-1:0] pc_o; int w;
        do_reset();
        ack_en = 1'b0;
        step = 1'b1;
        for (int i = 0; i < 45; i++) begin
            idle_cycle();
            if (mem_bus.mem_req) req_cnt++;
            if (mem_bus.mem_req && fault) fault_early = 1'b1;
            if (exec_en) exec_cnt++;
            if (i == 5) step = 1'b0;
        end
        checks++; if (req_cnt !== TMO) begin failures++; $display("FAIL timeout_req_cycles: got %0d expected %0d", req_cnt, TMO); end
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL timeout_fault: got %b expected 1", fault); end
        checks++; if (fault_early !== 1'b0) begin failures++; $display("FAIL timeout_fault_early: got %b expected 0", fault_early); end
        checks++; if ({pc, ir, mem_bus.mem_req} !== 25'd0) begin
            failures++; $display("FAIL timeout_state: got pc=%h ir=%h req=%b expected 00 0000 0", pc, ir, mem_bus.mem_req); end
        checks++; if (exec_cnt !== 0) begin failures++; $display("FAIL timeout_exec: got %0d expected 0", exec_cnt); end
        stray_ack = 1'b1;
        repeat (4) begin
            idle_cycle();
            if (exec_en) exec_cnt++;
        end
        stray_ack = 1'b0;
        checks++; if ({ir, 32'(exec_cnt)} !== 48'd0) begin failures++; $display("FAIL stray_ack_ignored: got ir=%h exec=%0d expected 0000 0", ir, exec_cnt); end
        ack_en = 1'b1;
        mem_array[0] = 16'h0800;
        step = 1'b1;
        exec_step(ctl(1, 1, 0, 0, 0, 0, 0, 0), ok, ir_o, op_o, pc_o, w);
        step = 1'b0;
        idle_cycle();
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL refetch_after_fault: got exec_seen=%b expected 1", ok); end
        checks++; if ({fault, pc} !== {1'b1, 8'h01}) begin failures++; $display("FAIL fault_sticky: got fault=%b pc=%h expected 1 01", fault, pc); end
    endtask

    task automatic test_halt();
        int req_cnt = 0, exec_cnt = 0; bit halt_drop = 1'b0;
        bit ok; logic [15:0] ir_o; logic [4:0] op_o; logic [AW-1:0] pc_o; int w;
        do_reset();
        mem_array[0] = 16'h0000;
        run = 1'b1;
        exec_step(ctl(1, 0, 0, 0, 0, 0, 0, 0), ok, ir_o, op_o, pc_o, w);
        idle_cycle();
        checks++; if ({halted, pc} !== {1'b1, 8'h01}) begin failures++; $display("FAIL halt_entry: got halted=%b pc=%h expected 1 01", halted, pc); end
        for (int i = 0; i < 20; i++) begin
            idle_cycle();
            step = i[1];
            if (mem_bus.mem_req) req_cnt++;
            if (exec_en) exec_cnt++;
            if (!halted) halt_drop = 1'b1;
        end
        checks++; if (req_cnt + exec_cnt !== 0) begin failures++; $display("FAIL halt_activity: got req=%0d exec=%0d expected 0 0", req_cnt, exec_cnt); end
        checks++; if (halt_drop !== 1'b0) begin failures++; $display("FAIL halt_sticky: got drop=%b expected 0", halt_drop); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({pc, ir, mem_bus.mem_req, exec_en, fault, halted} !== 28'd0) begin
            failures++; $display("FAIL halt_async_reset: got pc=%h ir=%h req=%b ex=%b fault=%b halted=%b expected all 0",
                                 pc, ir, mem_bus.mem_req, exec_en, fault, halted); end
    endtask

    task automatic test_rst_mid_fetch();
        bit seen = 1'b0; int activity = 0;
        do_reset();
        ack_lat = 6;
        run = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            idle_cycle();
            if (mem_bus.mem_req) seen = 1'b1;
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({seen, mem_bus.mem_req} !== 2'b10) begin failures++; $display("FAIL rst_mid_fetch_req: got seen=%b req=%b expected 1 0", seen, mem_bus.mem_req); end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stray_ack = 1'b1;
        repeat (5) begin
            idle_cycle();
            if (mem_bus.mem_req || exec_en) activity++;
        end
        stray_ack = 1'b0;
        checks++; if ({ir, 32'(activity)} !== 48'd0) begin failures++; $display("FAIL late_ack_ignored: got ir=%h activity=%0d expected 0000 0", ir, activity); end
    endtask

    task automatic test_random();
        logic [AW-1:0] m_pc = '0;
        bit m_zf = 1'b0, m_cf = 1'b0, m_taken;
        logic [7:0] c;
        bit ok; logic [15:0] ir_o; logic [4:0] op_o; logic [AW-1:0] pc_o; int w;
        do_reset();
        for (int a = 0; a < 256; a++) mem_array[a] = 16'($urandom);
        run = 1'b1;
        for (int n = 0; n < 80; n++) begin
            ack_lat = $urandom_range(0, 3);
            c = 8'($urandom);
            c[6] = 1'b1;
            exec_step(c, ok, ir_o, op_o, pc_o, w);
            checks++;
            if (!ok) begin failures++; $display("FAIL rand_exec_timeout: instr %0d got no exec_en expected one", n); break; end
            checks++;
            if ({ir_o, op_o, pc_o} !== {mem_array[m_pc], mem_array[m_pc][15:11], m_pc}) begin
                failures++; $display("FAIL rand_instr %0d: got ir=%h op=%0d pc=%h expected ir=%h op=%0d pc=%h",
                                     n, ir_o, op_o, pc_o, mem_array[m_pc], mem_array[m_pc][15:11], m_pc); end
            m_taken = c[3] | (c[5] & m_zf) | (c[4] & m_cf);
            if (c[7]) m_pc = m_taken ? mem_array[m_pc][7:0] : AW'(int'(m_pc) + 1);
            if (c[2]) begin m_zf = c[1]; m_cf = c[0]; end
        end
        idle_cycle();
        checks++; if (pc !== m_pc) begin failures++; $display("FAIL rand_final_pc: got %h expected %h", pc, m_pc); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_wrap();
        test_jz();
        test_flag_same_cycle();
        test_timeout();
        test_halt();
        test_rst_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
